// File: rtl/seq_count_ctrl_up_dn_target_if.sv
// Command and status bundle for the up/down target sequencer.
// master: command producer / status consumer.  slave: the sequencer.
interface seq_count_ctrl_up_dn_target_if #(
  parameter int unsigned NBITS = 3
);
  logic             cmd_val;
  logic             cmd_rdy;
  logic [NBITS-1:0] cmd_target;
  logic [1:0]       cmd_mode;
  logic             abort;
  logic [NBITS-1:0] count;
  logic             busy;
  logic             dir;
  logic [NBITS-1:0] steps;
  logic             done;
  logic             aborted;

  modport master (
    output cmd_val, cmd_target, cmd_mode, abort,
    input  cmd_rdy, count, busy, dir, steps, done, aborted
  );

  modport slave (
    input  cmd_val, cmd_target, cmd_mode, abort,
    output cmd_rdy, count, busy, dir, steps, done, aborted
  );
endinterface

// File: rtl/seq_count_ctrl_up_dn_target.sv
// Up/down counter sequencer: accepts a target and mode, then walks the
// counter one step per cycle toward the target (or loads it directly),
// reporting busy/dir/steps and a done or aborted pulse.
module seq_count_ctrl_up_dn_target #(
  parameter int unsigned NBITS = 3
) (
  input logic                           clk,
  input logic                           reset,
  seq_count_ctrl_up_dn_target_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MODE_SHORT = 2'b00,
    MODE_UP    = 2'b01,
    MODE_DOWN  = 2'b10,
    MODE_LOAD  = 2'b11
  } mode_e;

  state_e           state_q,   state_d;
  logic [NBITS-1:0] count_q,   count_d;
  logic [NBITS-1:0] target_q,  target_d;
  logic [NBITS-1:0] steps_q,   steps_d;
  logic             dir_q,     dir_d;
  logic             done_q,    done_d;
  logic             aborted_q, aborted_d;

  logic [NBITS-1:0] dist_up;
  logic [NBITS-1:0] dist_dn;
  logic [NBITS-1:0] count_next;
  mode_e            mode_in;

  assign mode_in = mode_e'(bus.cmd_mode);

  // Modular distances from the current count to the offered target.
  always_comb begin
    dist_up = bus.cmd_target - count_q;
    dist_dn = count_q - bus.cmd_target;
  end

  // One step along the latched direction, wrapping naturally at NBITS.
  always_comb begin
    count_next = dir_q ? (count_q - 1'b1) : (count_q + 1'b1);
  end

  // Next-state and datapath update for the IDLE/RUN controller.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    steps_d   = steps_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        // abort is ignored here; a pending command is still accepted.
        if (bus.cmd_val) begin
          steps_d = '0;
          if (mode_in == MODE_LOAD) begin
            count_d = bus.cmd_target;
            done_d  = 1'b1;
          end else if (dist_up == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = RUN;
            target_d = bus.cmd_target;
            case (mode_in)
              MODE_UP:   dir_d = 1'b0;
              MODE_DOWN: dir_d = 1'b1;
              default:   dir_d = (dist_up <= dist_dn) ? 1'b0 : 1'b1;
            endcase
          end
        end
      end

      RUN: begin
        if (bus.abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          count_d = count_next;
          steps_d = steps_q + 1'b1;
          if (count_next == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      target_q  <= '0;
      steps_q   <= '0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      steps_q   <= steps_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.cmd_rdy = (state_q == IDLE);
  assign bus.busy    = (state_q == RUN);
  assign bus.count   = count_q;
  assign bus.dir     = dir_q;
  assign bus.steps   = steps_q;
  assign bus.done    = done_q;
  assign bus.aborted = aborted_q;

endmodule

// File: doc/seq_count_ctrl_up_dn_target.md
Name: seq_count_ctrl_up_dn_target

Overview:
- Controller that sequences an internal NBITS up/down binary counter toward a commanded target value, one step per cycle.
- Supports four modes: shortest-path, up-only, down-only and immediate load.
- Sits between a command producer (valid/ready) and consumers of the running count, e.g. pointer/phase sequencers.
- Reports progress (busy, dir, steps) and completion or abort pulses.

Parameters:
NBITS, 3, width of the counter, target and step count.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_val  input  1  command valid.
cmd_rdy  output  1  command ready; 1 exactly when the FSM is in IDLE (combinational from state).
cmd_target  input  NBITS  target count value.
cmd_mode  input  2  00 shortest, 01 up-only, 10 down-only, 11 load.
abort  input  1  cancel the running command.
count  output  NBITS  current counter value (registered).
busy  output  1  1 while in RUN.
dir  output  1  direction of the current or last command: 0 up, 1 down.
steps  output  NBITS  steps taken by the current or last command.
done  output  1  one-cycle pulse: command completed.
aborted  output  1  one-cycle pulse: command aborted.

Behaviour:
- Reset (reset==0, asynchronous, takes effect with no clock edge):
  - state=IDLE, count=0, dir=0, steps=0, done=0, aborted=0, busy=0, cmd_rdy=1.
- States are IDLE and RUN. A command is accepted on a rising edge where cmd_val && cmd_rdy.
- Distance computation at acceptance, modulo 2^NBITS, with c = current count:
  - u = (cmd_target - c) mod 2^NBITS
  - dn = (c - cmd_target) mod 2^NBITS
- Mode 11 (load):
  - count<=cmd_target, steps<=0, dir unchanged.
  - done=1 for the following cycle; state stays IDLE; busy never asserts.
- Modes 00/01/10 with u==0:
  - No stepping; steps<=0, dir unchanged.
  - done=1 for the following cycle; state stays IDLE.
- Modes 00/01/10 with u!=0:
  - steps<=0, state<=RUN.
  - dir<=0 for up-only; dir<=1 for down-only.
  - Shortest mode: dir<=0 if u<=dn, else 1 (tie goes up).
  - count does not change on the accepting edge.
- RUN, each edge:
  - count<=count+1 (dir 0) or count-1 (dir 1), wrapping modulo 2^NBITS; steps<=steps+1.
  - If the new count equals the latched target: state<=IDLE and done=1 for the next cycle.
- Latency: a command of distance k shows count at the target, done=1 and cmd_rdy=1 in the k-th cycle after the accept edge. busy=1 for exactly k cycles.
- Back-to-back: a new command may be accepted in the done cycle.
- Maximum distance is 2^NBITS-1, so steps never overflows.
- cmd_val while in RUN: not accepted (cmd_rdy=0). The producer must hold cmd_val and its payload until accepted.
- abort:
  - In RUN: at the next edge, state<=IDLE, count and steps hold (no step on that edge), aborted=1 for one cycle, done=0.
  - In IDLE: ignored. If cmd_val is also high, the command is accepted normally.
- done and aborted are never high in the same cycle; both are 0 in all other cycles.
- The target and mode are latched at accept; cmd_target changes during RUN have no effect.

Test Plan:
1. Reset, shortest target 3 -> count 1,2,3 on successive cycles; dir=0; busy=1 for 3 cycles; done pulse with count=3, steps=3. Then shortest target 6 -> dir=1, count 2,1,0,7,6? No: from 3, u=3 and dn=5, so dir=0 and count 4,5,6 with steps=3.
2. From 0, shortest target 4 (tie) -> dir=0, count 1,2,3,4, steps=4. From 4, shortest target 4 -> done next cycle, busy never 1, steps=0.
3. From 5, up-only target 2 -> count 6,7,0,1,2, steps=5. From 2, down-only target 5 -> count 1,0,7,6,5, dir=1, steps=5.
4. Load target 5 from 0 -> count=5 and done=1 one cycle after accept, busy=0. Hold cmd_val with a second command during a RUN -> not accepted until the done cycle, then accepted there.
5. From 0, up-only target 7; abort after count=2 -> count stays 2, aborted=1 for one cycle, steps=2, cmd_rdy=1, done never asserted. Abort while IDLE with cmd_val=1 -> command accepted.
6. Drive reset low mid-RUN at count=4 between clock edges -> count=0, busy=0, cmd_rdy=1 immediately. After release, shortest target 1 -> count 1, done.
